encode_instr_tx: RTL
====================

// Module: encode_instr_tx
// PURPOSE
//  Byte-serial x86 instruction encoder; the transmit-side counterpart of operand decode.
//  Accepts one operand-form request: opcode, ModR/M fields, SIB, displacement and immediate.
//  Emits the encoded bytes in order on a valid/ready stream, one byte per handshake.
//  Used to generate decoder stimulus and to re-serialize decoded instructions.
//  Form codes are the OPND_ENC_* values from defines.v.
// PARAMETERS
//  LEN_W        4      width of instr_len (max 12 bytes)
//  OPSIZE_BYTE  8'h66  operand-size prefix byte (used only with ENC_OPSIZE_PREFIX_EN)
// PORTS
//  clk              in   1      clock, rising edge
//  rst_n            in   1      asynchronous active-low reset
//  req_valid        in   1      request present
//  req_ready        out  1      encoder idle; request accepted when req_valid&&req_ready
//  req_opcode       in   8      primary opcode byte
//  req_form         in   4      OPND_ENC_* operand form
//  req_mod          in   2      ModR/M.mod
//  req_reg          in   3      ModR/M.reg, or opcode[2:0] register for REG/REG_IMM/EAX_REG
//  req_rm           in   3      ModR/M.rm
//  req_sib          in   8      SIB byte, emitted only if required
//  req_disp         in   32     displacement, emitted little-endian
//  req_imm          in   32     immediate, emitted little-endian
//  req_imm_1byte    in   1      immediate is 8-bit
//  req_opsize_16    in   1      16-bit operand size
//  out_valid        out  1      out_byte valid
//  out_ready        in   1      sink accepts out_byte
//  out_byte         out  8      current instruction byte
//  out_last         out  1      out_byte is the final byte of the instruction
//  instr_len        out  LEN_W  byte count of the instruction in flight; latched at accept
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; out_valid=0, out_byte=0, out_last=0, instr_len=0.
//    req_ready=1 from IDLE after deassert; a reset mid-instruction drops the remaining bytes.
//  - req_ready = (state==IDLE). All req_* fields are latched on accept; later changes are ignored.
//  - Field presence, computed at accept:
//    - has_modrm: form is any MODREGRM_* form.
//    - has_sib: has_modrm && mod!=2'b11 && rm==3'b100.
//    - disp_len:
//      - 1 if has_modrm && mod==01.
//      - 4 if has_modrm && mod==10.
//      - 4 if has_modrm && mod==00 && rm==101.
//      - 4 if form==DISP.
//      - 0 otherwise.
//    - imm_len: 0 unless form is IMM, REG_IMM, EAX_IMM or a *_IMM ModR/M form.
//      When present: 1 if req_imm_1byte, else 4.
//    - Unknown forms: opcode byte only.
//  - Byte values:
//    - opcode = {req_opcode[7:3],req_reg} for REG, REG_IMM, EAX_REG; else req_opcode.
//    - ModR/M byte = {mod,reg,rm}.
//  - FSM: IDLE -> [PREFIX] -> OPC -> [MODRM] -> [SIB] -> [DISP] -> [IMM] -> IDLE.
//    Absent fields are skipped at transition time, never emitted.
//  - A 2-bit byte counter steps DISP/IMM bytes. It clears on entering each of those states.
//  - out_valid=1 in every non-IDLE state, with out_byte/out_last registered.
//    The state advances only on out_valid&&out_ready.
//  - Stall: while out_ready=0, out_byte, out_last and state hold stable.
//  - Latency: first byte valid the cycle after accept.
//    After the last byte's handshake: IDLE, req_ready=1 next cycle.
//    Minimum one bubble between instructions.
//  - out_last=1 exactly on the final byte (OPC for a 1-byte instruction).
//  - instr_len = prefix + 1 + has_modrm + has_sib + disp_len + imm_len. It holds until the next accept.
// CONFIGURATION
//  ENC_OPSIZE_PREFIX_EN defined:
//    - req_opsize_16=1 emits OPSIZE_BYTE in the PREFIX state before OPC.
//    - A non-1-byte immediate shrinks to 2 bytes; instr_len includes the prefix.
//  ENC_OPSIZE_PREFIX_EN undefined:
//    - req_opsize_16 is ignored; the PREFIX state is never entered.
//    - Immediates are 1 or 4 bytes only.
// TESTING
//  1. MODREGRM_RM_REG, opc=01, mod=11, reg=001, rm=000 -> 01 C8; out_last on C8; instr_len=2.
//  2. MODREGRM_RM_IMM, opc=81, mod=01, reg=000, rm=100, sib=24, disp=10, imm=12345678
//     -> 81 44 24 10 78 56 34 12; instr_len=8.
//  3. REG_IMM, opc=B8, reg=011, imm=DEADBEEF -> BB EF BE AD DE; instr_len=5.
//  4. Case 2 with out_ready=0 for 5 cycles on the disp byte -> out_byte=10, out_valid=1 held.
//     No byte is lost or duplicated.
//  5. rst_n=0 during the second IMM byte -> out_valid=0 immediately; req_ready=1 after release.
//     Case 1 then re-encodes as 01 C8.
//  6. MODREGRM_RM_IMM, opc=81, mod=11, reg=000, rm=000, imm=00001234, opsize_16=1:
//     - With ENC_OPSIZE_PREFIX_EN: 66 81 C0 34 12, instr_len=5.
//     - Without it: 81 C0 34 12 00 00, instr_len=6.

Source files
------------

// File: rtl/encode_instr_tx_if.sv
// Request/stream bundle for the byte-serial instruction encoder.
// master = request source and byte sink; slave = encoder.
interface encode_instr_tx_if #(
    parameter int LEN_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_opcode;
    logic [3:0]       req_form;
    logic [1:0]       req_mod;
    logic [2:0]       req_reg;
    logic [2:0]       req_rm;
    logic [7:0]       req_sib;
    logic [31:0]      req_disp;
    logic [31:0]      req_imm;
    logic             req_imm_1byte;
    logic             req_opsize_16;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_byte;
    logic             out_last;
    logic [LEN_W-1:0] instr_len;

    // Both sides: a transfer happens on a rising edge where valid && ready;
    // valid and its payload hold until that edge, ready may change freely.
    modport master (
        output req_valid, req_opcode, req_form, req_mod, req_reg, req_rm,
               req_sib, req_disp, req_imm, req_imm_1byte, req_opsize_16, out_ready,
        input  req_ready, out_valid, out_byte, out_last, instr_len
    );
    modport slave (
        input  req_valid, req_opcode, req_form, req_mod, req_reg, req_rm,
               req_sib, req_disp, req_imm, req_imm_1byte, req_opsize_16, out_ready,
        output req_ready, out_valid, out_byte, out_last, instr_len
    );
endinterface

// File: rtl/encode_instr_tx.sv
// Byte-serial x86 instruction encoder: one request in, encoded bytes out in order.
// Optional feature macro: ENC_OPSIZE_PREFIX_EN (operand-size prefix, 2-byte immediates).
module encode_instr_tx #(
    parameter int         LEN_W       = 4,
    parameter logic [7:0] OPSIZE_BYTE = 8'h66
) (
    input logic              clk,
    input logic              rst_n,
    encode_instr_tx_if.slave bus
);
    localparam logic [3:0] F_NONE         = 4'd0;
    localparam logic [3:0] F_REG          = 4'd1;
    localparam logic [3:0] F_REG_IMM      = 4'd2;
    localparam logic [3:0] F_EAX_REG      = 4'd3;
    localparam logic [3:0] F_EAX_IMM      = 4'd4;
    localparam logic [3:0] F_IMM          = 4'd5;
    localparam logic [3:0] F_DISP         = 4'd6;
    localparam logic [3:0] F_MRM_RM_REG   = 4'd7;
    localparam logic [3:0] F_MRM_REG_RM   = 4'd8;
    localparam logic [3:0] F_MRM_RM       = 4'd9;
    localparam logic [3:0] F_MRM_RM_IMM   = 4'd10;
    localparam logic [3:0] F_MRM_REG_IMM  = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE, S_PREFIX, S_OPC, S_MODRM, S_SIB, S_DISP, S_IMM
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0] rem_q;
    logic [7:0]       opc_q, modrm_q, sib_q;
    logic [31:0]      disp_q, imm_q;
    logic             has_modrm_q, has_sib_q;
    logic [2:0]       disp_len_q, imm_len_q;
    logic [7:0]       byte_d;
    logic             last_d;

    logic             prefix_c, is_modrm_c, is_imm_c, merge_c, has_sib_c;
    logic [2:0]       disp_len_c, imm_len_c;
    logic [7:0]       opc_c;
    logic [LEN_W-1:0] len_c;
    logic             accept, handshake;
    state_t           after_sib, after_modrm, after_opc;

`ifdef ENC_OPSIZE_PREFIX_EN
    assign prefix_c = bus.req_opsize_16;
`else
    assign prefix_c = 1'b0;
    logic unused_opsize;
    assign unused_opsize = ^{bus.req_opsize_16, OPSIZE_BYTE};
`endif

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.out_valid = (state_q != S_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign handshake     = bus.out_valid && bus.out_ready;

    // Field presence and byte count, decoded from the live request at accept time.
    always_comb begin
        is_modrm_c = (bus.req_form >= F_MRM_RM_REG) && (bus.req_form <= F_MRM_REG_IMM);
        is_imm_c   = (bus.req_form == F_IMM) || (bus.req_form == F_REG_IMM) ||
                     (bus.req_form == F_EAX_IMM) || (bus.req_form == F_MRM_RM_IMM) ||
                     (bus.req_form == F_MRM_REG_IMM);
        merge_c    = (bus.req_form == F_REG) || (bus.req_form == F_REG_IMM) ||
                     (bus.req_form == F_EAX_REG);
        has_sib_c  = is_modrm_c && (bus.req_mod != 2'b11) && (bus.req_rm == 3'b100);
        disp_len_c = 3'd0;
        if (is_modrm_c) begin
            if (bus.req_mod == 2'b01)
                disp_len_c = 3'd1;
            else if (bus.req_mod == 2'b10)
                disp_len_c = 3'd4;
            else if (bus.req_mod == 2'b00 && bus.req_rm == 3'b101)
                disp_len_c = 3'd4;
        end else if (bus.req_form == F_DISP) begin
            disp_len_c = 3'd4;
        end
        imm_len_c = 3'd0;
        if (is_imm_c)
            imm_len_c = bus.req_imm_1byte ? 3'd1 : (prefix_c ? 3'd2 : 3'd4);
        opc_c = merge_c ? {bus.req_opcode[7:3], bus.req_reg} : bus.req_opcode;
        len_c = LEN_W'(prefix_c) + LEN_W'(1) + LEN_W'(is_modrm_c) + LEN_W'(has_sib_c) +
                LEN_W'(disp_len_c) + LEN_W'(imm_len_c);
    end

    assign after_sib   = (disp_len_q != 3'd0) ? S_DISP : ((imm_len_q != 3'd0) ? S_IMM : S_IDLE);
    assign after_modrm = has_sib_q ? S_SIB : after_sib;
    assign after_opc   = has_modrm_q ? S_MODRM : after_sib;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = bus.out_byte;
        last_d  = bus.out_last;
        if (state_q == S_IDLE) begin
            if (accept) begin
                state_d = prefix_c ? S_PREFIX : S_OPC;
                cnt_d   = 2'd0;
                byte_d  = prefix_c ? OPSIZE_BYTE : opc_c;
                last_d  = (len_c == LEN_W'(1));
            end
        end else if (bus.out_ready) begin
            case (state_q)
                S_PREFIX: state_d = S_OPC;
                S_OPC:    state_d = after_opc;
                S_MODRM:  state_d = after_modrm;
                S_SIB:    state_d = after_sib;
                S_DISP: begin
                    if ({1'b0, cnt_q} == disp_len_q - 3'd1)
                        state_d = (imm_len_q != 3'd0) ? S_IMM : S_IDLE;
                    else
                        cnt_d = cnt_q + 2'd1;
                end
                S_IMM: begin
                    if ({1'b0, cnt_q} == imm_len_q - 3'd1)
                        state_d = S_IDLE;
                    else
                        cnt_d = cnt_q + 2'd1;
                end
                default: state_d = S_IDLE;
            endcase
            if (state_d != state_q)
                cnt_d = 2'd0;
            case (state_d)
                S_OPC:   byte_d = opc_q;
                S_MODRM: byte_d = modrm_q;
                S_SIB:   byte_d = sib_q;
                S_DISP:  byte_d = disp_q[{cnt_d, 3'b000} +: 8];
                S_IMM:   byte_d = imm_q[{cnt_d, 3'b000} +: 8];
                default: byte_d = 8'h00;
            endcase
            // rem_q still counts the byte being handed over now
            last_d = (state_d != S_IDLE) && (rem_q == LEN_W'(2));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 2'd0;
            rem_q         <= '0;
            bus.out_byte  <= 8'h00;
            bus.out_last  <= 1'b0;
            bus.instr_len <= '0;
            opc_q         <= 8'h00;
            modrm_q       <= 8'h00;
            sib_q         <= 8'h00;
            disp_q        <= 32'h0;
            imm_q         <= 32'h0;
            has_modrm_q   <= 1'b0;
            has_sib_q     <= 1'b0;
            disp_len_q    <= 3'd0;
            imm_len_q     <= 3'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus.out_byte <= byte_d;
            bus.out_last <= last_d;
            if (accept) begin
                rem_q         <= len_c;
                bus.instr_len <= len_c;
                opc_q         <= opc_c;
                modrm_q       <= {bus.req_mod, bus.req_reg, bus.req_rm};
                sib_q         <= bus.req_sib;
                disp_q        <= bus.req_disp;
                imm_q         <= bus.req_imm;
                has_modrm_q   <= is_modrm_c;
                has_sib_q     <= has_sib_c;
                disp_len_q    <= disp_len_c;
                imm_len_q     <= imm_len_c;
            end else if (handshake) begin
                rem_q <= rem_q - LEN_W'(1);
            end
        end
    end
endmodule
